// File: rtl/cell_hist.sv
// Orientation-histogram accumulator: sums gradient magnitudes into NBINS bins per
// CELL_PIX-sample cell, then streams the finished histogram one bin per cycle.

module cell_hist_bin #(
    parameter int MAG_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_take,
    input  logic              i_hit,
    input  logic              i_done,
    input  logic [MAG_W-1:0]  i_mag,
    output logic [DATA_W-1:0] o_shadow
);
    localparam int SW = DATA_W + 1;

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] w_acc_inc;
    logic [SW-1:0]     w_sum;

    // One spare carry bit detects overflow; the accumulator pins at all-ones.
    always_comb begin
        w_sum     = {1'b0, r_acc} + SW'(i_mag);
        w_acc_inc = r_acc;
        if (i_hit)
            w_acc_inc = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc    <= '0;
            r_shadow <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_take) begin
            if (i_done) begin
                r_shadow <= w_acc_inc;
                r_acc    <= '0;
            end else begin
                r_acc <= w_acc_inc;
            end
        end
    end

    assign o_shadow = r_shadow;
endmodule

module cell_hist #(
    parameter int MAG_W    = 16,
    parameter int DATA_W   = 32,
    parameter int NBINS    = 9,
    parameter int CELL_PIX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MAG_W-1:0]  i_mag,
    input  logic [3:0]        i_bin,
    input  logic              i_valid,
    input  logic              clear,
    output logic [DATA_W-1:0] o_data,
    output logic [3:0]        o_bin,
    output logic              o_valid,
    output logic              o_last
);
    localparam int         PW       = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;
    localparam logic [3:0] LAST_BIN = 4'(NBINS - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                        r_state, w_state_nxt;
    logic [PW-1:0]                 r_pcnt;
    logic [3:0]                    r_idx, w_idx_nxt;
    logic [NBINS-1:0][DATA_W-1:0]  w_shadow;
    logic                          w_take, w_done;
    logic                          w_ov, w_ol;
    logic [DATA_W-1:0]             w_od;

    assign w_take = i_valid & ~clear;
    assign w_done = w_take && (r_pcnt == PW'(CELL_PIX - 1));

    // Out-of-range bin indices hit no lane, so they only advance the pixel count.
    for (genvar k = 0; k < NBINS; k++) begin : g_bin
        cell_hist_bin #(.MAG_W(MAG_W), .DATA_W(DATA_W)) u_bin (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (clear),
            .i_take   (w_take),
            .i_hit    (i_bin == 4'(k)),
            .i_done   (w_done),
            .i_mag    (i_mag),
            .o_shadow (w_shadow[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_pcnt <= '0;
        else if (clear)
            r_pcnt <= '0;
        else if (w_take)
            r_pcnt <= w_done ? '0 : r_pcnt + 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state: a completion restarts the stream even on the final word of the previous one.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else if (w_done) begin
            w_state_nxt = S_STREAM;
            w_idx_nxt   = '0;
        end else if (r_state == S_STREAM) begin
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == LAST_BIN)
                w_state_nxt = S_IDLE;
        end
    end

    // Output decode
    always_comb begin
        w_ov = (r_state == S_STREAM) && !clear;
        w_ol = w_ov && (r_idx == LAST_BIN);
        w_od = w_shadow[r_idx];
    end

    // Data and bin hold their last values once the stream ends or is cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
            o_bin   <= '0;
        end else begin
            o_valid <= w_ov;
            o_last  <= w_ol;
            if (w_ov) begin
                o_data <= w_od;
                o_bin  <= r_idx;
            end
        end
    end
endmodule

// File: tb/tb_cell_hist.sv
// Self-checking bench for cell_hist: directed HOG cell scenarios plus random traffic,
// compared cycle by cycle against a sample-list histogram model.

module tb_cell_hist;
    localparam int MAG_W    = 16;
    localparam int DATA_W   = 20;
    localparam int NBINS    = 9;
    localparam int CELL_PIX = 64;
    localparam longint MAXV = (64'd1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [MAG_W-1:0]  i_mag = '0;
    logic [3:0]        i_bin = '0;
    logic              i_valid = 1'b0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] o_data;
    logic [3:0]        o_bin;
    logic              o_valid;
    logic              o_last;

    cell_hist #(.MAG_W(MAG_W), .DATA_W(DATA_W), .NBINS(NBINS), .CELL_PIX(CELL_PIX)) dut (
        .clk(clk), .rst(rst), .i_mag(i_mag), .i_bin(i_bin), .i_valid(i_valid),
        .clear(clear), .o_data(o_data), .o_bin(o_bin), .o_valid(o_valid), .o_last(o_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [3:0]        b;
        logic              l;
    } word_t;

    word_t             exp_q[$];
    int unsigned       cell_mag[$];
    int unsigned       cell_bin[$];
    logic [DATA_W-1:0] hold_d = '0;
    logic [3:0]        hold_b = '0;
    logic [DATA_W-1:0] cap[16];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Histogram of the finished cell, queued as the words the stream must carry.
    task automatic finish_cell();
        for (int b = 0; b < NBINS; b++) begin
            longint s = 0;
            word_t  w;
            for (int i = 0; i < cell_mag.size(); i++)
                if (cell_bin[i] == b) s += cell_mag[i];
            if (s > MAXV) s = MAXV;
            w.d = DATA_W'(s);
            w.b = 4'(b);
            w.l = (b == NBINS - 1);
            exp_q.push_back(w);
        end
        cell_mag.delete();
        cell_bin.delete();
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 16; i++) cap[i] = '0;
    endtask

    task automatic step(input logic v, input logic [15:0] m, input logic [3:0] b, input logic c);
        word_t w;
        logic  ev;
        w.d = '0; w.b = '0; w.l = 1'b0;
        i_valid = v; i_mag = m; i_bin = b; clear = c;
        @(posedge clk);
        ev = 1'b0;
        if (!rst) begin
            exp_q.delete(); cell_mag.delete(); cell_bin.delete();
            hold_d = '0; hold_b = '0;
        end else if (c) begin
            exp_q.delete(); cell_mag.delete(); cell_bin.delete();
        end else begin
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                ev = 1'b1;
                hold_d = w.d;
                hold_b = w.b;
            end
            if (v) begin
                cell_mag.push_back(m);
                cell_bin.push_back(b);
                if (cell_mag.size() == CELL_PIX) finish_cell();
            end
        end
        #1;
        chk("o_valid", o_valid, ev);
        chk("o_last", o_last, ev && w.l);
        chk("o_data", o_data, hold_d);
        chk("o_bin", o_bin, hold_b);
        if (o_valid) cap[o_bin] = o_data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 1'b0);
    endtask

    initial begin
        clear_cap();
        // Reset held, then idle
        rst = 1'b0;
        idle(5);
        rst = 1'b1;
        idle(4);

        // Ramp magnitudes across all bins at full rate
        clear_cap();
        for (int i = 0; i < CELL_PIX; i++) step(1'b1, 16'(i + 1), 4'(i % 9), 1'b0);
        idle(12);
        chk("t2_bin0", cap[0], 260);
        chk("t2_bin8", cap[8], 252);

        // Saturation on a single bin
        clear_cap();
        for (int i = 0; i < CELL_PIX; i++) step(1'b1, 16'hFFFF, 4'd3, 1'b0);
        idle(12);
        chk("t3_bin3_sat", cap[3], 32'hFFFFF);
        chk("t3_bin0", cap[0], 0);

        // Toggling valid with out-of-range bins mixed in
        clear_cap();
        for (int i = 0; i < CELL_PIX; i++) begin
            step(1'b1, 16'd2, (i % 16 == 7) ? 4'd12 : 4'd5, 1'b0);
            step(1'b0, 16'($urandom), 4'($urandom), 1'b0);
        end
        idle(12);
        chk("t4_bin5", cap[5], 120);
        chk("t4_bin4", cap[4], 0);

        // Back-to-back cells; second must not inherit residue from the first
        clear_cap();
        for (int i = 0; i < CELL_PIX; i++) step(1'b1, 16'($urandom), 4'($urandom_range(0, 8)), 1'b0);
        for (int i = 0; i < CELL_PIX; i++) step(1'b1, 16'd1, 4'd0, 1'b0);
        idle(12);
        chk("t5_bin0", cap[0], 64);
        chk("t5_bin1", cap[1], 0);

        // Clear mid-cell (with a colliding sample), then mid-stream
        for (int i = 0; i < 30; i++) step(1'b1, 16'($urandom), 4'($urandom_range(0, 8)), 1'b0);
        step(1'b1, 16'hFFFF, 4'd1, 1'b1);
        for (int i = 0; i < CELL_PIX; i++) step(1'b1, 16'($urandom), 4'($urandom_range(0, 8)), 1'b0);
        idle(4);
        step(1'b0, 16'd0, 4'd0, 1'b1);
        idle(3);
        clear_cap();
        for (int i = 0; i < CELL_PIX; i++) step(1'b1, 16'd3, 4'd1, 1'b0);
        idle(12);
        chk("t6_bin1", cap[1], 192);
        chk("t6_bin0", cap[0], 0);

        // Random traffic with sparse clears
        for (int i = 0; i < 600; i++)
            step(($urandom % 4) != 0, 16'($urandom), 4'($urandom % 16), ($urandom % 150) == 0);
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
